tt_um_uart_mvm: RTL and testbench



---
 rtl/uart_mvm_pkg.sv | 30 +++
 rtl/uart_mvm_if.sv | 10 +
 rtl/uart_mvm_core.sv | 243 ++++++++++++++++++++++++
 rtl/tt_um_uart_mvm.sv | 47 ++++
 tb/tb_tt_um_uart_mvm.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_mvm_pkg.sv
// Shared configuration for the UART matrix-vector multiplier: default
// geometry, UART timing, derived widths and FSM state encodings.
package uart_mvm_pkg;

    localparam int R                = 2;
    localparam int C                = 2;
    localparam int W_X              = 4;
    localparam int W_K              = 4;
    localparam int W_Y_OUT          = 8;
    localparam int CLOCKS_PER_PULSE = 54;
    localparam int BITS_PER_WORD    = 8;
    localparam int PACKET_SIZE_TX   = 13;

    // Full-precision accumulator width and frame sizes in UART words
    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int N_WORDS_KX = (R*C*W_K + C*W_X + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_WORDS_Y  = (R*W_Y_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

endpackage

// File: rtl/uart_mvm_if.sv
// Serial line pair between the pin wrapper (or a bench) and the core.
interface uart_mvm_if;
    import uart_mvm_pkg::*;

    logic rx;
    logic tx;

    modport master (output rx, input tx);
    modport slave  (input rx, output tx);
endinterface

// File: rtl/uart_mvm_core.sv
// UART receiver collecting x/k frames, signed matrix-vector product,
// one-deep result buffer and UART transmitter for the result words.
module uart_mvm_core #(
    parameter int R                = uart_mvm_pkg::R,
    parameter int C                = uart_mvm_pkg::C,
    parameter int W_X              = uart_mvm_pkg::W_X,
    parameter int W_K              = uart_mvm_pkg::W_K,
    parameter int W_Y_OUT          = uart_mvm_pkg::W_Y_OUT,
    parameter int CLOCKS_PER_PULSE = uart_mvm_pkg::CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = uart_mvm_pkg::BITS_PER_WORD,
    parameter int PACKET_SIZE_TX   = uart_mvm_pkg::PACKET_SIZE_TX
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_mvm_if.slave bus
);
    import uart_mvm_pkg::*;

    localparam int W_ACC     = W_X + W_K + $clog2(C);
    localparam int N_KX      = (R*C*W_K + C*W_X + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int N_Y       = (R*W_Y_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;
    localparam int KX_W      = N_KX * BITS_PER_WORD;
    localparam int RES_W     = N_Y * BITS_PER_WORD;
    localparam int STOP_BITS = PACKET_SIZE_TX - BITS_PER_WORD - 1;
    localparam int HALF      = CLOCKS_PER_PULSE / 2;
    localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
    localparam int RXB_W     = $clog2(BITS_PER_WORD);
    localparam int TXB_W     = $clog2(PACKET_SIZE_TX);
    localparam int KXI_W     = (N_KX > 1) ? $clog2(N_KX) : 1;
    localparam int YI_W      = (N_Y > 1) ? $clog2(N_Y) : 1;

    // Results are transmitted modulo 2^W_Y_OUT (plain wrap, no saturation)
    function automatic logic [W_Y_OUT-1:0] wrap_y(input logic signed [W_ACC-1:0] v);
        return v[W_Y_OUT-1:0];
    endfunction

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [RXB_W-1:0] rx_bit_q, rx_bit_d;
    logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
    logic [KXI_W-1:0] byte_idx_q, byte_idx_d;
    logic [KX_W-1:0]  frame_q, frame_d;
    logic             mvm_go_q, mvm_go_d;

    logic signed [W_X-1:0]   mvm_x;
    logic signed [W_K-1:0]   mvm_k;
    logic signed [W_ACC-1:0] mvm_prod, mvm_acc;
    logic [RES_W-1:0]        y_pack;

    logic [RES_W-1:0] buf_q, buf_d;
    logic             buf_vld_q, buf_vld_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [TXB_W-1:0] tx_bit_q, tx_bit_d;
    logic [YI_W-1:0]  tx_word_q, tx_word_d;
    logic [RES_W-1:0] tx_res_q, tx_res_d;
    logic [PACKET_SIZE_TX-1:0] tx_pkt_q, tx_pkt_d;
    logic             tx_load;

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state, counters and frame assembly registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
            mvm_go_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            mvm_go_q   <= mvm_go_d;
        end
    end

    // RX next state: verify start at half bit, sample data at bit centres,
    // shift each finished byte into the frame from the top so byte0 ends lowest
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        mvm_go_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_W'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[BITS_PER_WORD-1:1]};
                    if (rx_bit_q == RXB_W'(BITS_PER_WORD - 1)) begin
                        // Stop bit is not checked; the next falling edge restarts
                        rx_state_d = RX_IDLE;
                        frame_d    = {rx_shift_d, frame_q[KX_W-1:BITS_PER_WORD]};
                        if (byte_idx_q == KXI_W'(N_KX - 1)) begin
                            byte_idx_d = '0;
                            mvm_go_d   = 1'b1;
                        end else begin
                            byte_idx_d = byte_idx_q + KXI_W'(1);
                        end
                    end else begin
                        rx_bit_d = rx_bit_q + RXB_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Signed matrix-vector product over the assembled frame
    always_comb begin
        mvm_x    = '0;
        mvm_k    = '0;
        mvm_prod = '0;
        mvm_acc  = '0;
        y_pack   = '0;
        for (int r = 0; r < R; r++) begin
            mvm_acc = '0;
            for (int c = 0; c < C; c++) begin
                mvm_x    = frame_q[c*W_X +: W_X];
                mvm_k    = frame_q[C*W_X + (r*C + c)*W_K +: W_K];
                mvm_prod = W_ACC'(mvm_k) * W_ACC'(mvm_x);
                mvm_acc  = mvm_acc + mvm_prod;
            end
            y_pack[r*W_Y_OUT +: W_Y_OUT] = wrap_y(mvm_acc);
        end
    end

    // Output buffer and TX registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            buf_vld_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_word_q  <= '0;
            tx_res_q   <= '0;
            tx_pkt_q   <= '1;
        end else begin
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_word_q  <= tx_word_d;
            tx_res_q   <= tx_res_d;
            tx_pkt_q   <= tx_pkt_d;
        end
    end

    // TX next state: take the buffered result when idle, send each word as
    // start + data + stop bits; a new result always wins the buffer slot
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_word_d  = tx_word_q;
        tx_res_d   = tx_res_q;
        tx_pkt_d   = tx_pkt_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (buf_vld_q) begin
                    tx_load    = 1'b1;
                    tx_state_d = TX_SEND;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_word_d  = '0;
                    tx_res_d   = buf_q;
                    tx_pkt_d   = {{STOP_BITS{1'b1}}, buf_q[BITS_PER_WORD-1:0], 1'b0};
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == TXB_W'(PACKET_SIZE_TX - 1)) begin
                        tx_bit_d = '0;
                        if (tx_word_q == YI_W'(N_Y - 1)) begin
                            tx_state_d = TX_IDLE;
                        end else begin
                            tx_word_d = tx_word_q + YI_W'(1);
                            tx_res_d  = tx_res_q >> BITS_PER_WORD;
                            tx_pkt_d  = {{STOP_BITS{1'b1}}, tx_res_d[BITS_PER_WORD-1:0], 1'b0};
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + TXB_W'(1);
                        tx_pkt_d = {1'b1, tx_pkt_q[PACKET_SIZE_TX-1:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        buf_d     = buf_q;
        buf_vld_d = buf_vld_q & ~tx_load;
        if (mvm_go_q) begin
            buf_d     = y_pack;
            buf_vld_d = 1'b1;
        end
    end

    assign bus.tx = (tx_state_q == TX_SEND) ? tx_pkt_q[0] : 1'b1;

endmodule

// File: rtl/tt_um_uart_mvm.sv
// Pin wrapper: maps the UART lines onto the user pins and ties the rest off.
module tt_um_uart_mvm #(
    parameter int R                = uart_mvm_pkg::R,
    parameter int C                = uart_mvm_pkg::C,
    parameter int W_X              = uart_mvm_pkg::W_X,
    parameter int W_K              = uart_mvm_pkg::W_K,
    parameter int W_Y_OUT          = uart_mvm_pkg::W_Y_OUT,
    parameter int CLOCKS_PER_PULSE = uart_mvm_pkg::CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = uart_mvm_pkg::BITS_PER_WORD,
    parameter int PACKET_SIZE_TX   = uart_mvm_pkg::PACKET_SIZE_TX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import uart_mvm_pkg::*;

    uart_mvm_if u_bus ();
    logic unused_pins;

    assign u_bus.rx    = ui_in[0];
    assign uo_out      = {7'b0, u_bus.tx};
    assign uio_out     = '0;
    assign uio_oe      = '0;
    assign unused_pins = &{1'b0, ena, ui_in[7:1], uio_in};

    uart_mvm_core #(
        .R                (R),
        .C                (C),
        .W_X              (W_X),
        .W_K              (W_K),
        .W_Y_OUT          (W_Y_OUT),
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD),
        .PACKET_SIZE_TX   (PACKET_SIZE_TX)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus.slave)
    );

endmodule

// File: tb/tb_tt_um_uart_mvm.sv
// Bench for tt_um_uart_mvm: drives UART frames, decodes the TX line and
// compares each result byte and its stop bits against expected values.
module tb_tt_um_uart_mvm;
    localparam int CPP = 54;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    uart_mvm_if bus ();

    assign ui_in  = {7'b0, bus.rx};
    assign bus.tx = uo_out[0];

    tt_um_uart_mvm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mon_q[$];
    logic       stop_q[$];
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;
    logic       mon_st;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nib(input logic [3:0] n);
        return (n >= 4'd8) ? int'(n) - 16 : int'(n);
    endfunction

    // Reference: y[r] = k[r][0]*x[0] + k[r][1]*x[1], wrapped to 8 bits
    function automatic logic [15:0] ref_y(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
        int y0;
        int y1;
        y0 = nib(b1[3:0]) * nib(b0[3:0]) + nib(b1[7:4]) * nib(b0[7:4]);
        y1 = nib(b2[3:0]) * nib(b0[3:0]) + nib(b2[7:4]) * nib(b0[7:4]);
        return {8'(y1), 8'(y0)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx = 1'b0;
        idle(CPP);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            idle(CPP);
        end
        bus.rx = 1'b1;
        idle(CPP);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int gap);
        send_byte(b0);
        idle(gap);
        send_byte(b1);
        idle(gap);
        send_byte(b2);
    endtask

    task automatic expect_pair(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        int waited;
        logic [7:0] b;
        logic s;
        waited = 0;
        while (mon_q.size() < 2 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (mon_q.size() < 2) begin
            check_val({tag, "_timeout_bytes"}, 32'(mon_q.size()), 32'd2);
        end else begin
            b = mon_q.pop_front();
            s = stop_q.pop_front();
            check_val({tag, "_y0"}, 32'(b), 32'(e0));
            check_val({tag, "_stop0"}, 32'(s), 32'd1);
            b = mon_q.pop_front();
            s = stop_q.pop_front();
            check_val({tag, "_y1"}, 32'(b), 32'(e1));
            check_val({tag, "_stop1"}, 32'(s), 32'd1);
        end
    endtask

    // TX line decoder: samples at bit centres, records data and stop-bit status
    initial begin
        forever begin
            @(negedge clk);
            if (mon_prev && !bus.tx && rst_n) begin
                idle(CPP / 2);
                if (!bus.tx) begin
                    for (int i = 0; i < 8; i++) begin
                        idle(CPP);
                        mon_b[i] = bus.tx;
                    end
                    mon_st = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        idle(CPP);
                        mon_st = mon_st & bus.tx;
                    end
                    mon_q.push_back(mon_b);
                    stop_q.push_back(mon_st);
                end
            end
            mon_prev = bus.tx;
        end
    end

    logic [7:0]  rb0[10];
    logic [7:0]  rb1[10];
    logic [7:0]  rb2[10];
    logic [15:0] ry;

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        idle(5);
        check_val("rst_uo_out", 32'(uo_out), 32'h01);
        check_val("rst_uio_out", 32'(uio_out), 32'h00);
        check_val("rst_uio_oe", 32'(uio_oe), 32'h00);
        rst_n = 1'b1;
        idle(10);

        send_frame(8'h21, 8'h43, 8'h65, 1);
        expect_pair("vec_basic", 8'h0B, 8'h11);

        send_frame(8'h88, 8'h88, 8'h88, 3);
        expect_pair("vec_min", 8'h80, 8'h80);

        send_frame(8'h1F, 8'h87, 8'hFF, 7);
        expect_pair("vec_mixed", 8'hF1, 8'h00);

        // Short low pulse that is gone by the half-bit check
        bus.rx = 1'b0;
        idle(6);
        bus.rx = 1'b1;
        idle(CPP * 2);
        send_frame(8'h21, 8'h43, 8'h65, 2);
        expect_pair("glitch", 8'h0B, 8'h11);

        // Back-to-back random frames; results must come out in order
        for (int f = 0; f < 10; f++) begin
            rb0[f] = 8'($urandom);
            rb1[f] = 8'($urandom);
            rb2[f] = 8'($urandom);
            send_byte(rb0[f]);
            idle($urandom_range(20, 1));
            send_byte(rb1[f]);
            idle($urandom_range(20, 1));
            send_byte(rb2[f]);
            idle($urandom_range(100, 1));
        end
        for (int f = 0; f < 10; f++) begin
            ry = ref_y(rb0[f], rb1[f], rb2[f]);
            expect_pair($sformatf("rand%0d", f), ry[7:0], ry[15:8]);
        end

        // Reset after two bytes must discard the partial frame
        send_byte(8'h11);
        idle(4);
        send_byte(8'h22);
        idle(4);
        rst_n = 1'b0;
        idle(1);
        check_val("midrst_uo_out", 32'(uo_out), 32'h01);
        idle(4);
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h21, 8'h43, 8'h65, 5);
        expect_pair("after_rst", 8'h0B, 8'h11);
        idle(3000);
        check_val("after_rst_extra", 32'(mon_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
